seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider consuming the add/subtract stage's result and carry. Each cycle it issues a trial subtraction and uses carry-out (no-borrow) to accept or restore the partial remainder. It produces one quotient bit per cycle. It sits downstream of the operand registers and takes its trial arithmetic from an adder-subtractor operating in subtract mode.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- dividend  in  WIDTH  unsigned dividend, captured on accepted start
- divisor  in  WIDTH  unsigned divisor, captured on accepted start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse, results valid
- quotient  out  WIDTH  unsigned quotient, held until next accepted start
- remainder  out  WIDTH  unsigned remainder, held until next accepted start
- div_by_zero  out  1  high with done when captured divisor was 0; held with results

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start: capture operands; R←0, Q←dividend, count←0 → RUN.
- RUN, each cycle: shift {R,Q} left one bit; T = R_shifted − D on WIDTH+1 bits (m=1); carry=1 (no borrow) → R←T, Q[0]←1; else R←R_shifted, Q[0]←0; count++.
- After WIDTH iterations → DONE. Load quotient←Q, remainder←R[WIDTH-1:0].
- DONE lasts one cycle with done=1. Next state IDLE, or RUN if start is asserted (back-to-back accepted).
- start in RUN is ignored; no queueing.
- Subtractor overflow output v is unused. Only carry is used.
- Reset (any state, including mid-RUN): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.

## Timing
- Start accepted at edge E0. busy=1 from E0 through the edge entering DONE.
- Normal latency: done=1 in the cycle after edge E0+WIDTH (WIDTH+1 cycles after acceptance).
- quotient/remainder update at the edge entering DONE. Stable until next DONE or reset.
- busy=0 in IDLE and DONE.
- Throughput: one division per WIDTH+1 cycles with back-to-back start.
- Operands may change after E0 without effect.

## Configuration
- SEQ_DIV_ZERO_CHECK_EN defined: divisor==0 at accept goes straight to DONE at edge E0+1.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - Latency is 2 cycles.
- Undefined: no short-circuit. Zero divisor runs the full WIDTH iterations, giving the same quotient/remainder naturally.
  - div_by_zero tied 0.

## Structure
- Shared package seq_div_pkg: state enum (IDLE, RUN, DONE), DIV_WIDTH_DEFAULT=4, count width function clog2(WIDTH+1).
- One sub-module: div_trial_sub, a (WIDTH+1)-bit adder-subtractor.
  - Port set S, c, v, A, B, m, matching the existing binarySubtractor convention.
  - Instantiated with m tied 1, A=R_shifted, B={1'b0,D}.
- Remaining logic (FSM, shift registers, counter, output registers) lives in seq_divider.

## Test plan
- rst high for 2 cycles mid-RUN (after 2 iterations) → next cycle busy=0, done=0, quotient=0, remainder=0; subsequent 7/2 gives correct result.
- dividend=7, divisor=2, start 1 cycle → done 5 cycles later, quotient=3, remainder=1, div_by_zero=0.
- 10/1 → quotient=10, remainder=0.
- 15/13 → quotient=1, remainder=2.
- 3/14 → quotient=0, remainder=3.
- Start held high continuously:
  - 9/4 is accepted, then 11/3 re-pulsed during RUN is ignored; result is quotient=2, remainder=1.
  - Start held in DONE is accepted back-to-back.
- 9/0 with SEQ_DIV_ZERO_CHECK_EN → done 2 cycles after accept, quotient=15, remainder=9, div_by_zero=1.
- 9/0 without the macro → done after 5 cycles, quotient=15, remainder=9, div_by_zero=0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Used by seq_divider, seq_divider_if and the divider testbench.
package seq_div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    // Iteration counter width: enough bits to hold 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider.
// master: requester (drives start/operands); slave: the divider.
interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_trial_sub.sv
// N-bit adder-subtractor (binarySubtractor port convention).
// m=1 computes A-B as A + ~B + 1; c is the carry-out (1 = no borrow),
// v is the two's-complement overflow flag.
module div_trial_sub #(
    parameter int unsigned N = 5
) (
    output logic [N-1:0] S,
    output logic         c,
    output logic         v,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         m
);
    logic [N-1:0] b_x;

    assign b_x      = B ^ {N{m}};
    assign {c, S}   = {1'b0, A} + {1'b0, b_x} + (N+1)'(m);
    assign v        = (A[N-1] == b_x[N-1]) && (S[N-1] != A[N-1]);
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Optional macro SEQ_DIV_ZERO_CHECK_EN: a zero divisor short-circuits to
// DONE one cycle after acceptance and raises div_by_zero.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_full;
    logic             trial_c;
    logic             trial_v_unused;
    logic             r_msb_unused;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;

    assign r_shift = {r, q[WIDTH-1]};

    div_trial_sub #(.N(WIDTH + 1)) u_trial (
        .S (trial),
        .c (trial_c),
        .v (trial_v_unused),
        .A (r_shift),
        .B ({1'b0, d}),
        .m (1'b1)
    );

    // The restored/accepted remainder is always below the divisor, so its MSB is dropped.
    assign r_full       = trial_c ? trial : r_shift;
    assign r_msb_unused = r_full[WIDTH];
    assign r_next       = r_full[WIDTH-1:0];
    assign q_next       = {q[WIDTH-2:0], trial_c};

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic dbz_q;
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;

    // FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            count  <= '0;
            r      <= '0;
            q      <= '0;
            d      <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            dbz_q  <= 1'b0;
`endif
        end else if (accept) begin
            r      <= '0;
            q      <= bus.dividend;
            d      <= bus.divisor;
            count  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            state  <= RUN;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                end
                RUN: begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    if (d == '0) begin
                        // No shifts have happened yet, so q still holds the dividend.
                        quot_q <= '1;
                        rem_q  <= q;
                        dbz_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else
`endif
                    begin
                        r     <= r_next;
                        q     <= q_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            quot_q <= q_next;
                            rem_q  <= r_next;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                            dbz_q  <= 1'b0;
`endif
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference (a/b, a%b). Honours SEQ_DIV_ZERO_CHECK_EN.
module tb_seq_divider;
    import seq_div_pkg::*;

    localparam int unsigned W = 4;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of division.
    task automatic ref_div(input int a, input int b, output int eq, output int er,
                           output int edbz, output int elat);
        if (b == 0) begin
            eq   = (1 << W) - 1;
            er   = a;
            edbz = ZC ? 1 : 0;
            elat = ZC ? 2 : W + 1;
        end else begin
            eq   = a / b;
            er   = a % b;
            edbz = 0;
            elat = W + 1;
        end
    endtask

    // Called at the first falling edge after acceptance; waits for done and checks results.
    task automatic collect(input int a, input int b, input bit check_hold);
        int eq, er, edbz, elat, n;
        string id;
        ref_div(a, b, eq, er, edbz, elat);
        id = $sformatf("%0d/%0d", a, b);
        check({"busy_run ", id}, 32'(bus.busy), 1);
        n = 1;
        while (!bus.done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check({"done_seen ", id}, 32'(bus.done), 1);
        if (bus.done) begin
            check({"latency ", id}, n, elat);
            check({"quotient ", id}, 32'(bus.quotient), eq);
            check({"remainder ", id}, 32'(bus.remainder), er);
            check({"dbz ", id}, 32'(bus.div_by_zero), edbz);
            check({"busy_done ", id}, 32'(bus.busy), 0);
            if (check_hold) begin
                @(negedge clk);
                check({"done_pulse ", id}, 32'(bus.done), 0);
                check({"quot_hold ", id}, 32'(bus.quotient), eq);
                check({"rem_hold ", id}, 32'(bus.remainder), er);
            end
        end
    endtask

    task automatic run_div(input int a, input int b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        @(negedge clk);
        bus.start    = 1'b0;
        // Operands changing after acceptance must not matter.
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        collect(a, b, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_quot", 32'(bus.quotient), 0);
        check("rst_rem", 32'(bus.remainder), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        rst = 1'b0;

        run_div(7, 2);
        run_div(10, 1);
        run_div(15, 13);
        run_div(3, 14);
        run_div(9, 0);
        run_div(0, 5);
        run_div(15, 15);
        run_div(15, 1);

        // Reset after two iterations of a division in flight.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_quot", 32'(bus.quotient), 0);
        check("midrst_rem", 32'(bus.remainder), 0);
        check("midrst_dbz", 32'(bus.div_by_zero), 0);
        run_div(7, 2);

        // Start held high: re-request during RUN ignored, accepted from DONE.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd4;
        @(negedge clk);
        bus.dividend = 4'd11;
        bus.divisor  = 4'd3;
        collect(9, 4, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        collect(11, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
